// File: rtl/mesi_bus_pkg.sv
// Shared definitions for the MESI coherence bus: bus codes, FSM states, helpers.
package mesi_bus_pkg;

  localparam logic [2:0] BUS_NONE    = 3'b000;
  localparam logic [2:0] BUS_RD_MISS = 3'b001;
  localparam logic [2:0] BUS_WR_MISS = 3'b010;
  localparam logic [2:0] BUS_WB      = 3'b011;
  localparam logic [2:0] BUS_INV     = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BCAST = 2'd2,
    WB    = 2'd3
  } state_t;

  // A message needs a write-back phase if either code field is a write-back.
  function automatic logic has_wb(input logic [5:0] msg);
    return (msg[5:3] == BUS_WB) || (msg[2:0] == BUS_WB);
  endfunction

endpackage

// File: rtl/mesi_bus_arbiter_rr.sv
// Round-robin winner selection: first set request at or above ptr, with wrap.
module rr_arbiter
  import mesi_bus_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         any_c,
  output logic [N-1:0] win_c,
  output logic [2:0]   idx_c
);

  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

  int unsigned j;

  // Scan from ptr upward; the first hit wins and masks later candidates.
  always_comb begin
    any_c = 1'b0;
    win_c = '0;
    idx_c = '0;
    j     = 0;
    for (int i = 0; i < int'(N); i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any_c && req[SEL_W'(j)]) begin
        any_c              = 1'b1;
        win_c[SEL_W'(j)]   = 1'b1;
        idx_c              = 3'(j);
      end
    end
  end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Snooping-bus arbiter/sequencer: grant, broadcast, snoop-ack collection, write-back hold.
module mesi_bus_arbiter
  import mesi_bus_pkg::*;
#(
  parameter int unsigned N_CACHES  = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned WB_CYCLES = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic [N_CACHES-1:0]        req,
  input  logic [6*N_CACHES-1:0]      req_msg,
  input  logic [ADDR_W*N_CACHES-1:0] req_addr,
  input  logic [N_CACHES-1:0]        snoop_ack,
  output logic [N_CACHES-1:0]        gnt,
  output logic                       bus_valid,
  output logic [5:0]                 bus_msg,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [2:0]                 bus_src,
  output logic                       bus_wb,
  output logic                       bus_err,
  output logic                       busy
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned WCNT_W = $clog2(WB_CYCLES + 1);

  state_t              state;
  logic [2:0]          ptr;
  logic [N_CACHES-1:0] ack_seen;
  logic [TCNT_W-1:0]   tcnt;
  logic [WCNT_W-1:0]   wcnt;

  logic                any_c;
  logic [N_CACHES-1:0] win_c;
  logic [2:0]          win_idx_c;
  logic [5:0]          win_msg_c;
  logic [ADDR_W-1:0]   win_addr_c;
  logic [N_CACHES-1:0] others_c;
  logic                ack_all_c;

  rr_arbiter #(.N(N_CACHES)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .any_c (any_c),
    .win_c (win_c),
    .idx_c (win_idx_c)
  );

  // Select the winner's message and address slice.
  always_comb begin
    win_msg_c  = '0;
    win_addr_c = '0;
    for (int i = 0; i < int'(N_CACHES); i++) begin
      if (win_c[i]) begin
        win_msg_c  = req_msg[6*i +: 6];
        win_addr_c = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // Snoop completion: every non-source cache acked now or earlier in BCAST.
  always_comb begin
    others_c  = ~(N_CACHES'(1) << bus_src);
    ack_all_c = ((ack_seen | snoop_ack) & others_c) == others_c;
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      ptr       <= '0;
      ack_seen  <= '0;
      tcnt      <= '0;
      wcnt      <= '0;
      gnt       <= '0;
      bus_valid <= 1'b0;
      bus_msg   <= '0;
      bus_addr  <= '0;
      bus_src   <= '0;
      bus_wb    <= 1'b0;
      bus_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt     <= '0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_c) begin
            gnt      <= win_c;
            bus_msg  <= win_msg_c;
            bus_addr <= win_addr_c;
            bus_src  <= win_idx_c;
            ptr      <= (win_idx_c == 3'(N_CACHES - 1)) ? 3'd0 : win_idx_c + 3'd1;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (bus_msg == {BUS_NONE, BUS_NONE}) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ack_seen  <= '0;
            tcnt      <= '0;
            bus_valid <= 1'b1;
            state     <= BCAST;
          end
        end
        BCAST: begin
          if (ack_all_c) begin
            bus_valid <= 1'b0;
            if (has_wb(bus_msg)) begin
              wcnt   <= '0;
              bus_wb <= 1'b1;
              state  <= WB;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            bus_valid <= 1'b0;
            bus_err   <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tcnt     <= tcnt + TCNT_W'(1);
            ack_seen <= ack_seen | (snoop_ack & others_c);
          end
        end
        WB: begin
          if (wcnt == WCNT_W'(WB_CYCLES - 1)) begin
            bus_wb <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed self-checking bench for mesi_bus_arbiter (N_CACHES=4, ADDR_W=8, WB_CYCLES=4, TIMEOUT=15).
module tb_mesi_bus_arbiter;

  logic        CLK;
  logic        CLR;
  logic [3:0]  req;
  logic [23:0] req_msg;
  logic [31:0] req_addr;
  logic [3:0]  snoop_ack;
  logic [3:0]  gnt;
  logic        bus_valid;
  logic [5:0]  bus_msg;
  logic [7:0]  bus_addr;
  logic [2:0]  bus_src;
  logic        bus_wb;
  logic        bus_err;
  logic        busy;

  int checks;
  int errors;

  mesi_bus_arbiter #(
    .N_CACHES(4), .ADDR_W(8), .WB_CYCLES(4), .TIMEOUT(15)
  ) dut (
    .CLK(CLK), .CLR(CLR), .req(req), .req_msg(req_msg), .req_addr(req_addr),
    .snoop_ack(snoop_ack), .gnt(gnt), .bus_valid(bus_valid), .bus_msg(bus_msg),
    .bus_addr(bus_addr), .bus_src(bus_src), .bus_wb(bus_wb), .bus_err(bus_err),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [5:0] msg, input logic [7:0] addr);
    req_msg[6*i +: 6]  = msg;
    req_addr[8*i +: 8] = addr;
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    req = '0;
    snoop_ack = '0;
    tick();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    req_msg  = '1;
    req_addr = '1;
    do_reset();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0 || bus_valid !== 1'b0 || bus_wb !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b valid=%b wb=%b err=%b exp all 0", busy, bus_valid, bus_wb, bus_err); end
    checks++; if (bus_msg !== 6'd0 || bus_addr !== 8'd0 || bus_src !== 3'd0) begin
      errors++; $display("FAIL reset_latches got msg=%h addr=%h src=%0d exp 0", bus_msg, bus_addr, bus_src); end
  endtask

  task automatic test_single();
    do_reset();
    set_slot(1, 6'b000001, 8'h3C);
    snoop_ack = 4'b1101;
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got %b exp 0010", gnt); end
    checks++; if (bus_msg !== 6'b000001 || bus_addr !== 8'h3C || bus_src !== 3'd1) begin
      errors++; $display("FAIL single_latch got msg=%b addr=%h src=%0d exp 000001 3c 1", bus_msg, bus_addr, bus_src); end
    checks++; if (busy !== 1'b1 || bus_valid !== 1'b0) begin
      errors++; $display("FAIL single_grant_phase got busy=%b valid=%b exp 1 0", busy, bus_valid); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || bus_valid !== 1'b1) begin
      errors++; $display("FAIL single_bcast got gnt=%b valid=%b exp 0000 1", gnt, bus_valid); end
    tick();
    checks++; if (bus_valid !== 1'b0 || busy !== 1'b0 || bus_wb !== 1'b0) begin
      errors++; $display("FAIL single_done got valid=%b busy=%b wb=%b exp 0 0 0", bus_valid, busy, bus_wb); end
    snoop_ack = '0;
  endtask

  task automatic test_contention();
    int exp_order [3];
    logic [3:0] exp_gnt;
    bit found;
    exp_order = '{0, 1, 3};
    do_reset();
    set_slot(0, 6'b000001, 8'h10);
    set_slot(1, 6'b000010, 8'h11);
    set_slot(3, 6'b000100, 8'h13);
    snoop_ack = 4'b1111;
    req = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
        tick();
        if (gnt !== 4'b0000) found = 1'b1;
      end
      exp_gnt = 4'(1) << exp_order[k];
      checks++; if (!found || gnt !== exp_gnt) begin
        errors++; $display("FAIL contention_gnt%0d got %b exp %b", k, gnt, exp_gnt); end
      checks++; if (bus_src !== 3'(exp_order[k])) begin
        errors++; $display("FAIL contention_src%0d got %0d exp %0d", k, bus_src, exp_order[k]); end
      req[exp_order[k]] = 1'b0;
    end
    for (int c = 0; c < 10 && busy; c++) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL contention_idle got busy=%b exp 0", busy); end
    // Pointer must have wrapped to 0: cache 0 beats cache 1.
    req = 4'b0011;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL contention_ptr_wrap got %b exp 0001", gnt); end
    req = 4'b0000;
    for (int c = 0; c < 10 && busy; c++) tick();
    snoop_ack = '0;
  endtask

  task automatic test_writeback();
    int nwb;
    do_reset();
    set_slot(2, 6'b010011, 8'hA5);
    snoop_ack = 4'b0000;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wb_gnt got %b exp 0100", gnt); end
    req = 4'b0000;
    tick();
    tick();
    tick();
    checks++; if (bus_valid !== 1'b1 || bus_wb !== 1'b0) begin
      errors++; $display("FAIL wb_bcast3 got valid=%b wb=%b exp 1 0", bus_valid, bus_wb); end
    snoop_ack = 4'b1011;
    tick();
    snoop_ack = 4'b0000;
    checks++; if (bus_valid !== 1'b0 || bus_wb !== 1'b1) begin
      errors++; $display("FAIL wb_enter got valid=%b wb=%b exp 0 1", bus_valid, bus_wb); end
    nwb = 0;
    for (int c = 0; c < 20 && bus_wb; c++) begin
      nwb++;
      tick();
    end
    checks++; if (nwb != 4) begin errors++; $display("FAIL wb_len got %0d exp 4", nwb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wb_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_timeout();
    int nv;
    bit early_err;
    do_reset();
    set_slot(0, 6'b000001, 8'h77);
    snoop_ack = 4'b0110;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    nv = 0;
    early_err = 1'b0;
    for (int c = 0; c < 40 && bus_valid; c++) begin
      nv++;
      if (bus_err) early_err = 1'b1;
      tick();
    end
    checks++; if (nv != 15) begin errors++; $display("FAIL timeout_len got %0d exp 15", nv); end
    checks++; if (bus_err !== 1'b1 || early_err) begin
      errors++; $display("FAIL timeout_err got err=%b early=%b exp 1 0", bus_err, early_err); end
    checks++; if (bus_wb !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_idle got wb=%b busy=%b exp 0 0", bus_wb, busy); end
    tick();
    checks++; if (bus_err !== 1'b0 || bus_wb !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse got err=%b wb=%b exp 0 0", bus_err, bus_wb); end
    snoop_ack = '0;
  endtask

  task automatic test_reset_mid_wb();
    do_reset();
    set_slot(1, 6'b011001, 8'h5A);
    set_slot(2, 6'b000001, 8'hC3);
    snoop_ack = 4'b1111;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    tick();
    checks++; if (bus_wb !== 1'b1) begin errors++; $display("FAIL midrst_wb_hi got %b exp 1", bus_wb); end
    tick();
    CLR = 1'b1;
    req = 4'b0100;
    tick();
    CLR = 1'b0;
    checks++; if (gnt !== 4'b0000 || bus_valid !== 1'b0 || bus_wb !== 1'b0 || busy !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got gnt=%b valid=%b wb=%b busy=%b err=%b exp all 0",
                         gnt, bus_valid, bus_wb, busy, bus_err); end
    checks++; if (bus_msg !== 6'd0 || bus_addr !== 8'd0 || bus_src !== 3'd0) begin
      errors++; $display("FAIL midrst_latches got msg=%h addr=%h src=%0d exp 0", bus_msg, bus_addr, bus_src); end
    tick();
    checks++; if (gnt !== 4'b0100 || bus_src !== 3'd2 || bus_addr !== 8'hC3) begin
      errors++; $display("FAIL midrst_regrant got gnt=%b src=%0d addr=%h exp 0100 2 c3", gnt, bus_src, bus_addr); end
    req = 4'b0000;
    for (int c = 0; c < 10 && busy; c++) tick();
    snoop_ack = '0;
  endtask

  task automatic test_noop_selfack();
    do_reset();
    set_slot(1, 6'b000000, 8'h01);
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010 || busy !== 1'b1) begin
      errors++; $display("FAIL noop_gnt got gnt=%b busy=%b exp 0010 1", gnt, busy); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || bus_valid !== 1'b0) begin
      errors++; $display("FAIL noop_end got gnt=%b busy=%b valid=%b exp 0000 0 0", gnt, busy, bus_valid); end
    tick();
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL noop_novalid got %b exp 0", bus_valid); end
    // Source acking itself must not finish the broadcast.
    set_slot(1, 6'b000100, 8'h02);
    snoop_ack = 4'b0010;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    checks++; if (bus_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL selfack_hold got valid=%b busy=%b exp 1 1", bus_valid, busy); end
    snoop_ack = 4'b1111;
    tick();
    snoop_ack = 4'b0000;
    checks++; if (bus_valid !== 1'b0 || busy !== 1'b0 || bus_wb !== 1'b0) begin
      errors++; $display("FAIL selfack_done got valid=%b busy=%b wb=%b exp 0 0 0", bus_valid, busy, bus_wb); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    CLR       = 1'b1;
    req       = '0;
    req_msg   = '0;
    req_addr  = '0;
    snoop_ack = '0;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_writeback();
    test_timeout();
    test_reset_mid_wb();
    test_noop_selfack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesi_bus_arbiter.md
Name: mesi_bus_arbiter

Overview:
Snooping-bus arbiter and sequencer for the MESI coherence fabric. It shares one coherence bus among N per-cache emitter FSMs using round-robin arbitration. Each granted transaction runs as follows: latch the 6-bit bus message, broadcast it to all other caches, collect snoop acknowledges, and hold the bus for a write-back phase when the message carries a write-back code.

Parameters:
N_CACHES, 4, number of requesting caches (2..8)
ADDR_W, 8, block address width
WB_CYCLES, 4, cycles the bus is held for a write-back (>=1)
TIMEOUT, 15, max BCAST cycles waiting for acks before error (>=1)

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  synchronous active-high reset
req  in  N_CACHES  per-cache bus request; held until gnt
req_msg  in  6*N_CACHES  per-cache message {hi[2:0],lo[2:0]}, slice i = [6i+5:6i]
req_addr  in  ADDR_W*N_CACHES  per-cache block address
snoop_ack  in  N_CACHES  per-cache snoop-complete pulse/level
gnt  out  N_CACHES  one-hot grant, 1-cycle pulse
bus_valid  out  1  broadcast phase active
bus_msg  out  6  latched message
bus_addr  out  ADDR_W  latched address
bus_src  out  3  index of granted cache
bus_wb  out  1  write-back phase active
bus_err  out  1  1-cycle pulse on ack timeout
busy  out  1  state != IDLE

Behaviour:
- One clock, CLK; reset is synchronous and active-high on CLR. At a CLR edge, all outputs go to 0, state goes to IDLE, the round-robin pointer goes to 0, and the counters and ack_seen clear. This applies in every state, including mid-BCAST and mid-WB.
- Bus codes (3-bit fields): 000 none, 001 read miss, 010 write miss, 011 write-back, 100 invalidate.
- States: IDLE, GRANT, BCAST, WB.
- IDLE:
  - req is sampled only in IDLE.
  - If any req bit is set, the winner is the first set bit scanning from ptr upward with wrap.
  - At that edge: latch req_msg/req_addr of the winner into bus_msg/bus_addr, set bus_src, set gnt[winner]=1, enter GRANT, set ptr = (winner+1) mod N_CACHES.
  - With no request: stay in IDLE; outputs hold 0 except that bus_msg/bus_addr/bus_src retain their last values.
- GRANT: one cycle; gnt drops at the next edge.
  - If bus_msg == 6'b000000 (no-op), return to IDLE; bus_valid never asserts.
  - Otherwise enter BCAST and clear ack_seen and the timeout counter.
- BCAST:
  - bus_valid=1.
  - Each cycle: ack_seen |= snoop_ack & ~onehot(bus_src). The source's own ack is ignored.
  - Exit when (ack_seen | snoop_ack) covers all non-source bits; an ack in the same cycle counts.
  - On exit: if bus_msg[5:3]==011 or bus_msg[2:0]==011, enter WB; otherwise go to IDLE.
  - If TIMEOUT cycles elapse in BCAST without full acks: pulse bus_err for 1 cycle and go to IDLE. No WB phase is entered.
- WB: bus_wb=1 for exactly WB_CYCLES cycles, bus_valid=0, then IDLE.
- Latency:
  - req seen at edge k → gnt high in cycle k+1.
  - bus_valid first high in cycle k+2.
  - Minimum transaction is 3 cycles (acks already present at BCAST entry). The next grant can occur at the edge ending the final cycle.
- Arbitration rules:
  - Simultaneous requests are served round-robin. No requester is granted twice while another is pending; worst-case wait is N_CACHES-1 transactions.
  - A req deasserted before being sampled is lost silently.
  - Requests arriving while busy wait for IDLE.
  - gnt is always one-hot or zero.

Decomposition:
- Package mesi_bus_pkg holds:
  - the bus-code constants (BUS_NONE, BUS_RD_MISS, BUS_WR_MISS, BUS_WB, BUS_INV);
  - the state localparams (IDLE, GRANT, BCAST, WB);
  - a function has_wb(msg).
- Sub-module rr_arbiter: combinational next-winner from (req, ptr), producing a one-hot grant and an index. This is the natural split.
- The top level holds the FSM, the counters and the latches.

Test Plan:
- Single request: req=0010, msg=6'b000001, addr=8'h3C, other acks high from BCAST entry → gnt=0010 for one cycle, then bus_valid for 1 cycle with bus_msg=000001, bus_addr=3C, bus_src=1, then IDLE; no bus_wb.
- Contention: req=1011 held (each requester drops its req on its gnt), ptr=0 → grant order 0,1,3; ptr=0 afterward; no double grant.
- Write-back message: cache 2 sends 6'b010011, acks arrive 2 cycles into BCAST → bus_valid for 3 cycles, then bus_wb high for exactly 4 cycles, then busy=0.
- Timeout: cache 0 sends 001, cache 3 never acks → bus_err pulses once at BCAST cycle 15, FSM returns to IDLE, bus_wb never asserts.
- Reset mid-operation: CLR high for 1 cycle during WB cycle 2 → next cycle all outputs 0, IDLE, ptr=0; a pending req=0100 is granted to cache 2 on the following edge.
- No-op and self-ack: cache 1 sends 6'b000000 → gnt pulse only, busy for 1 cycle, no bus_valid. Separately, source cache 1 asserting its own snoop_ack alone does not end BCAST.
